hdlverifier_data_jtag_wr: RTL
=============================

# hdlverifier_data_jtag_wr

JTAG shift-in data writer for the HDL Verifier capture/injection path: the write-direction counterpart of the JTAG shift-out data reader. Deserializes bits arriving on the JTAG shift-in stream into DATA_WIDTH-bit words and writes them into the on-chip buffer through a single-port write interface. Words are accepted in host-sized chunks; a toggle handshake on `newChunk` releases each chunk. Runs entirely in the TCK domain; the instantiating core ties `clk` to `tck`.

## Interface
- `DATA_WIDTH`, 8, buffer word width in bits (≥2).
- `ADDR_WIDTH`, 4, buffer address width; depth = 2^ADDR_WIDTH words.
- `clk`  in  1  JTAG TCK; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high; one clock; all state cleared immediately.
- `shift_in_state`  in  1  high while the JTAG core is in the data shift-in state.
- `shift_in_en`  in  1  qualifies `shift_in_data` on this edge.
- `shift_in_data`  in  1  serial data, LSB of each word first.
- `newChunk`  in  1  host toggle; a change of level releases the next chunk.
- `chunkSize`  in  ADDR_WIDTH  words per chunk minus one (0 → 1 word, 2^ADDR_WIDTH−1 → full depth).
- `wr`  out  1  one-cycle buffer write strobe.
- `waddr`  out  ADDR_WIDTH  write address, valid while `wr`=1.
- `wr_data`  out  DATA_WIDTH  write data, valid while `wr`=1.
- `rdy_recv`  out  1  high when the current chunk is complete and the block waits for `newChunk`.
- `full`  out  1  sticky; buffer holds 2^ADDR_WIDTH words.
- `word_count`  out  ADDR_WIDTH+1  total words written since reset.

## Operation
- Bit accept = `shift_in_state & shift_in_en` in state SHIFT.
  - Accepted bit enters the shift register at the MSB, shifting right, so the first bit ends at bit 0.
  - Bit counter runs 0..DATA_WIDTH−1.
- States:
  - IDLE: entered on reset; moves to SHIFT when `shift_in_state`=1.
  - SHIFT: on accept with bit counter = DATA_WIDTH−1, the word completes.
    - `wr` is issued and the bit counter clears.
    - `shift_in_state`=0 returns to IDLE and discards any partial word (bit counter → 0). Address and chunk counts are kept.
  - WAIT_CHUNK: entered after the write of the last word of a chunk (chunk counter = `chunkSize`).
    - `rdy_recv`=1; all shift-in bits are dropped.
    - A `newChunk` level differing from the stored acknowledge bit clears `rdy_recv`, clears the chunk counter, updates the acknowledge bit and moves to SHIFT (or IDLE if `shift_in_state`=0).
  - FULL: entered after the write that makes `word_count` = 2^ADDR_WIDTH. Takes priority over WAIT_CHUNK.
    - `full`=1, `rdy_recv`=1.
    - All further bits and `newChunk` toggles are ignored; only `reset` exits.
- Acknowledge bit handling:
  - Outside WAIT_CHUNK, the acknowledge bit tracks `newChunk` every cycle, so stale toggles are never honoured.
  - Reset loads the acknowledge bit from `newChunk`.
- `waddr` increments by 1 after each write. It never wraps, because FULL blocks the write that would wrap it.
- `chunkSize` is sampled at each chunk start (leaving IDLE, or on release from WAIT_CHUNK). Changes mid-chunk have no effect.

## Timing
- Reset values: `wr`=0, `waddr`=0, `wr_data`=0, `rdy_recv`=0, `full`=0, `word_count`=0; state IDLE.
- Write latency:
  - `wr` rises on the edge after the edge that accepted the word's last bit, and stays high exactly 1 cycle.
  - `wr_data` and `waddr` are registered and hold their values until the next write.
- `waddr` and `word_count` update on the edge that drops `wr`.
- `rdy_recv` and `full` rise on the same edge that drops `wr` for the last word.
- Back-to-back words: the minimum spacing between `wr` pulses is DATA_WIDTH cycles.
  - The first bit of the next word may be accepted in the same cycle `wr` is high.
- Release: `rdy_recv` falls 1 cycle after the `newChunk` edge is sampled.
  - The first bit of the new chunk is accepted no earlier than the cycle after `rdy_recv` falls.
- Asynchronous `reset` mid-word or mid-write: the outputs clear immediately and the partial word is lost.

## Test plan (DATA_WIDTH=8, ADDR_WIDTH=4)
- Reset, then shift 0xA5 LSB-first with `chunkSize`=3 → one `wr` pulse with `waddr`=0 and `wr_data`=0xA5, one cycle after the 8th bit; then `word_count`=1 and `rdy_recv`=0.
- Shift 4 words 0x01..0x04 with `chunkSize`=3 → writes at addresses 0..3; `rdy_recv`=1; a 5th word shifted in is dropped (no `wr`). Toggle `newChunk` → `rdy_recv` falls 1 cycle later; the next word is written to `waddr`=4.
- Shift 5 bits, drop `shift_in_state`, then shift 0x3C → the single write has `wr_data`=0x3C; the partial bits never appear.
- `chunkSize`=15, shift 16 words → `full`=1 and `rdy_recv`=1 after the write to address 15; 17th word and `newChunk` toggle are ignored; `word_count`=16.
- Toggle `newChunk` while in SHIFT, then fill the chunk → `rdy_recv` stays high until a fresh toggle.
- Assert `reset` during the 6th bit of a word → all outputs are 0 immediately; after release the next full word is written to `waddr`=0.

Source files
------------

// File: rtl/hdlverifier_data_jtag_wr.sv
// ============================================================================
// Module   : hdlverifier_data_jtag_wr
// Brief    : JTAG shift-in deserializer writing DATA_WIDTH-bit words into a
//            buffer, released chunk by chunk through a newChunk toggle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hdlverifier_data_jtag_wr #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  shift_in_state,
    input  logic                  shift_in_en,
    input  logic                  shift_in_data,
    input  logic                  newChunk,
    input  logic [ADDR_WIDTH-1:0] chunkSize,
    output logic                  wr,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rdy_recv,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int                  c_BCW       = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_BCW-1:0]    c_LAST_BIT  = c_BCW'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH:0] c_LAST_WORD = (ADDR_WIDTH + 1)'((1 << ADDR_WIDTH) - 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_SHIFT      = 2'd1,
        S_WAIT_CHUNK = 2'd2,
        S_FULL       = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic [c_BCW-1:0]        bitcnt_q, bitcnt_d;
    logic                    done_q, done_d;
    logic                    wr_q, wr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [ADDR_WIDTH:0]     word_count_q, word_count_d;
    logic [ADDR_WIDTH-1:0]   chunk_cnt_q, chunk_cnt_d;
    logic [ADDR_WIDTH-1:0]   chunk_size_q, chunk_size_d;
    logic                    nc_q;
    logic                    ack_q, ack_d;
    logic                    rdy_q, rdy_d;
    logic                    full_q, full_d;

    // The acknowledge bit is loaded from the live newChunk level so that a
    // level already present at reset is never mistaken for a release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            done_q       <= 1'b0;
            wr_q         <= 1'b0;
            wr_data_q    <= '0;
            waddr_q      <= '0;
            word_count_q <= '0;
            chunk_cnt_q  <= '0;
            chunk_size_q <= '0;
            nc_q         <= newChunk;
            ack_q        <= newChunk;
            rdy_q        <= 1'b0;
            full_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bitcnt_q     <= bitcnt_d;
            done_q       <= done_d;
            wr_q         <= wr_d;
            wr_data_q    <= wr_data_d;
            waddr_q      <= waddr_d;
            word_count_q <= word_count_d;
            chunk_cnt_q  <= chunk_cnt_d;
            chunk_size_q <= chunk_size_d;
            nc_q         <= newChunk;
            ack_q        <= ack_d;
            rdy_q        <= rdy_d;
            full_q       <= full_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bitcnt_d     = bitcnt_q;
        done_d       = 1'b0;
        wr_d         = 1'b0;
        wr_data_d    = wr_data_q;
        waddr_d      = waddr_q;
        word_count_d = word_count_q;
        chunk_cnt_d  = chunk_cnt_q;
        chunk_size_d = chunk_size_q;
        ack_d        = ack_q;
        rdy_d        = rdy_q;
        full_d       = full_q;

        // Word pipeline: last bit -> done_q -> wr_q -> bookkeeping.
        if (done_q) begin
            wr_d      = 1'b1;
            wr_data_d = shreg_q;
        end

        case (state_q)
            S_IDLE: begin
                ack_d = nc_q;
                if (shift_in_state) begin
                    state_d      = S_SHIFT;
                    chunk_size_d = chunkSize;
                end
            end
            S_SHIFT: begin
                ack_d = nc_q;
                if (!shift_in_state) begin
                    state_d  = S_IDLE;
                    bitcnt_d = '0;
                end else if (shift_in_en) begin
                    shreg_d = {shift_in_data, shreg_q[DATA_WIDTH-1:1]};
                    if (bitcnt_q == c_LAST_BIT) begin
                        bitcnt_d = '0;
                        done_d   = 1'b1;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
            end
            S_WAIT_CHUNK: begin
                if (nc_q != ack_q) begin
                    ack_d        = nc_q;
                    rdy_d        = 1'b0;
                    chunk_cnt_d  = '0;
                    chunk_size_d = chunkSize;
                    state_d      = shift_in_state ? S_SHIFT : S_IDLE;
                end
            end
            default: begin
            end
        endcase

        // Write retirement; entering WAIT_CHUNK/FULL discards any bits
        // that arrived after the chunk's last word.
        if (wr_q) begin
            word_count_d = word_count_q + 1'b1;
            if (word_count_q == c_LAST_WORD) begin
                state_d  = S_FULL;
                full_d   = 1'b1;
                rdy_d    = 1'b1;
                bitcnt_d = '0;
                done_d   = 1'b0;
            end else begin
                waddr_d = waddr_q + 1'b1;
                if (chunk_cnt_q == chunk_size_q) begin
                    state_d  = S_WAIT_CHUNK;
                    rdy_d    = 1'b1;
                    bitcnt_d = '0;
                    done_d   = 1'b0;
                end else begin
                    chunk_cnt_d = chunk_cnt_q + 1'b1;
                end
            end
        end
    end

    assign wr         = wr_q;
    assign waddr      = waddr_q;
    assign wr_data    = wr_data_q;
    assign rdy_recv   = rdy_q;
    assign full       = full_q;
    assign word_count = word_count_q;

endmodule

`default_nettype wire
